// File: rtl/xor_lane_parity_acc.sv
// Streaming lane-parity accumulator. Each WIDTH-bit word is reduced to LANES
// parity bits and XOR-accumulated across a frame. One parity vector and a
// saturating word count are produced for each frame, through a one-deep
// output register.
module xor_lane_parity_acc #(
  parameter int WIDTH = 32,
  parameter int LANES = 4,
  parameter int ODD   = 0,
  parameter int CNTW  = 16
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             I_VALID,
  output logic             I_READY,
  input  logic [WIDTH-1:0] I_DATA,
  input  logic             I_LAST,
  input  logic             I_ABORT,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [LANES-1:0] O_PAR,
  output logic [CNTW-1:0]  O_WORDS,
  output logic             O_OVF
);

  localparam int unsigned LW = WIDTH / LANES;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic             s1_full_q, s1_full_d;
  logic [LANES-1:0] s1_par_q, s1_par_d;
  logic             s1_last_q, s1_last_d;
  logic [LANES-1:0] acc_q, acc_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             o_valid_q, o_valid_d;
  logic [LANES-1:0] o_par_q, o_par_d;
  logic [CNTW-1:0]  o_words_q, o_words_d;
  logic             o_ovf_q, o_ovf_d;

  logic [LANES-1:0] lane_par;
  logic [LANES-1:0] odd_mask;
  logic [CNTW-1:0]  cnt_inc;
  logic             cnt_max;
  logic             ovf_nxt;
  logic             consume;
  logic             accept;

  // Per-lane parity of the incoming word, plus the saturating count/overflow step.
  always_comb begin
    lane_par = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_par[l] = ^I_DATA[l*LW +: LW];
    end
    odd_mask = (ODD != 0) ? '1 : '0;
    cnt_max  = (cnt_q == '1);
    cnt_inc  = cnt_max ? cnt_q : cnt_q + CNTW'(1);
    ovf_nxt  = ovf_q | cnt_max;
  end

  // Datapath: S1 handshake, frame accumulation, output capture and drain.
  // Abort suppresses the S1 consume so a discarded word never reaches acc or the output.
  always_comb begin
    consume   = s1_full_q & (~s1_last_q | ~o_valid_q | O_READY) & ~I_ABORT;
    I_READY   = RN & ~I_ABORT & (~s1_full_q | consume);
    accept    = I_VALID & I_READY;

    s1_full_d = s1_full_q;
    s1_par_d  = s1_par_q;
    s1_last_d = s1_last_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    o_valid_d = o_valid_q;
    o_par_d   = o_par_q;
    o_words_d = o_words_q;
    o_ovf_d   = o_ovf_q;

    if (O_READY) begin
      o_valid_d = 1'b0;
    end

    if (consume) begin
      s1_full_d = 1'b0;
      acc_d     = acc_q ^ s1_par_q;
      cnt_d     = cnt_inc;
      ovf_d     = ovf_nxt;
      if (s1_last_q) begin
        o_par_d   = acc_q ^ s1_par_q ^ odd_mask;
        o_words_d = cnt_inc;
        o_ovf_d   = ovf_nxt;
        o_valid_d = 1'b1;
        acc_d     = '0;
        cnt_d     = '0;
        ovf_d     = 1'b0;
      end
    end

    if (accept) begin
      s1_full_d = 1'b1;
      s1_par_d  = lane_par;
      s1_last_d = I_LAST;
    end

    if (I_ABORT) begin
      s1_full_d = 1'b0;
      acc_d     = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
    end
  end

  // Frame-state next-state logic.
  always_comb begin
    state_d = state_q;
    if (consume) begin
      if (!s1_last_q) begin
        state_d = ST_FRAME;
      end else if (O_READY) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_HOLD;
      end
    end else if (state_q == ST_HOLD) begin
      if (O_READY) begin
        state_d = ST_IDLE;
      end
    end else if (I_ABORT) begin
      state_d = ST_IDLE;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q   <= ST_IDLE;
      s1_full_q <= 1'b0;
      s1_par_q  <= '0;
      s1_last_q <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      o_valid_q <= 1'b0;
      o_par_q   <= '0;
      o_words_q <= '0;
      o_ovf_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_full_q <= s1_full_d;
      s1_par_q  <= s1_par_d;
      s1_last_q <= s1_last_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      o_valid_q <= o_valid_d;
      o_par_q   <= o_par_d;
      o_words_q <= o_words_d;
      o_ovf_q   <= o_ovf_d;
    end
  end

  assign O_VALID = o_valid_q;
  assign O_PAR   = o_par_q;
  assign O_WORDS = o_words_q;
  assign O_OVF   = o_ovf_q;

endmodule

// File: tb/tb_xor_lane_parity_acc.sv
// Bench for xor_lane_parity_acc: three instances (even parity, odd parity,
// 4-bit counter) share one stimulus stream; a scoreboard of expected frame
// results is filled on accepted words and drained on output handshakes.
module tb_xor_lane_parity_acc;

  localparam int WIDTH  = 32;
  localparam int LANES  = 4;
  localparam int CNTW   = 16;
  localparam int CNTW_S = 4;

  logic             clk = 1'b0;
  logic             rn = 1'b0;
  logic             i_valid = 1'b0;
  logic [WIDTH-1:0] i_data = '0;
  logic             i_last = 1'b0;
  logic             i_abort = 1'b0;
  logic             o_ready = 1'b0;

  logic              i_ready_a, i_ready_b, i_ready_c;
  logic              o_valid_a, o_valid_b, o_valid_c;
  logic [LANES-1:0]  o_par_a, o_par_b, o_par_c;
  logic [CNTW-1:0]   o_words_a, o_words_b;
  logic [CNTW_S-1:0] o_words_c;
  logic              o_ovf_a, o_ovf_b, o_ovf_c;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef struct packed {
    logic [LANES-1:0]  par;
    logic [CNTW-1:0]   words_a;
    logic              ovf_a;
    logic [CNTW_S-1:0] words_c;
    logic              ovf_c;
  } exp_t;

  exp_t sb[$];

  xor_lane_parity_acc #(.WIDTH(WIDTH), .LANES(LANES), .ODD(0), .CNTW(CNTW)) u_even (
    .CLK(clk), .RN(rn), .I_VALID(i_valid), .I_READY(i_ready_a), .I_DATA(i_data),
    .I_LAST(i_last), .I_ABORT(i_abort), .O_VALID(o_valid_a), .O_READY(o_ready),
    .O_PAR(o_par_a), .O_WORDS(o_words_a), .O_OVF(o_ovf_a)
  );

  xor_lane_parity_acc #(.WIDTH(WIDTH), .LANES(LANES), .ODD(1), .CNTW(CNTW)) u_odd (
    .CLK(clk), .RN(rn), .I_VALID(i_valid), .I_READY(i_ready_b), .I_DATA(i_data),
    .I_LAST(i_last), .I_ABORT(i_abort), .O_VALID(o_valid_b), .O_READY(o_ready),
    .O_PAR(o_par_b), .O_WORDS(o_words_b), .O_OVF(o_ovf_b)
  );

  xor_lane_parity_acc #(.WIDTH(WIDTH), .LANES(LANES), .ODD(0), .CNTW(CNTW_S)) u_sat (
    .CLK(clk), .RN(rn), .I_VALID(i_valid), .I_READY(i_ready_c), .I_DATA(i_data),
    .I_LAST(i_last), .I_ABORT(i_abort), .O_VALID(o_valid_c), .O_READY(o_ready),
    .O_PAR(o_par_c), .O_WORDS(o_words_c), .O_OVF(o_ovf_c)
  );

  always #5 clk = ~clk;

  // Reference lane parity: walk every bit and toggle the owning lane.
  function automatic logic [LANES-1:0] ref_par(input logic [WIDTH-1:0] d);
    logic [LANES-1:0] r;
    r = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (d[b]) r[b / (WIDTH / LANES)] = ~r[b / (WIDTH / LANES)];
    end
    return r;
  endfunction

  // Samples mid-cycle: the values seen here are what the next rising edge acts on.
  task automatic run_monitor();
    logic [LANES-1:0] m_acc;
    int unsigned      m_cnt;
    int unsigned      cyc;
    logic             held;
    logic [LANES-1:0] h_par;
    logic [CNTW-1:0]  h_words;
    logic             h_ovf;
    exp_t             e;
    m_acc = '0; m_cnt = 0; cyc = 0; held = 1'b0;
    h_par = '0; h_words = '0; h_ovf = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin
        n_err++;
        $display("FAIL watchdog: cycles=%0d required<=20000", cyc);
        $fatal(1, "watchdog expired");
      end
      if (!rn) begin
        sb.delete();
        m_acc = '0; m_cnt = 0; held = 1'b0;
      end else begin
        if (i_abort) begin
          m_acc = '0; m_cnt = 0;
        end else if (i_valid && i_ready_a) begin
          m_acc = m_acc ^ ref_par(i_data);
          m_cnt++;
          if (i_last) begin
            e.par     = m_acc;
            e.words_a = (m_cnt > 32'd65535) ? 16'hFFFF : m_cnt[15:0];
            e.ovf_a   = (m_cnt > 32'd65535);
            e.words_c = (m_cnt > 32'd15) ? 4'hF : m_cnt[3:0];
            e.ovf_c   = (m_cnt > 32'd15);
            sb.push_back(e);
            m_acc = '0; m_cnt = 0;
          end
        end
        if (o_valid_a) begin
          if (held) begin
            n_vec++;
            if ({o_par_a, o_words_a, o_ovf_a} !== {h_par, h_words, h_ovf}) begin
              n_err++;
              $display("FAIL hold_stable: par=%b words=%0d ovf=%b required par=%b words=%0d ovf=%b",
                       o_par_a, o_words_a, o_ovf_a, h_par, h_words, h_ovf);
            end
          end
          if (o_ready) begin
            held = 1'b0;
            if (sb.size() == 0) begin
              n_vec++; n_err++;
              $display("FAIL unexpected_result: par=%b words=%0d required no result", o_par_a, o_words_a);
            end else begin
              e = sb.pop_front();
              n_vec++;
              if ({o_par_a, o_words_a, o_ovf_a} !== {e.par, e.words_a, e.ovf_a}) begin
                n_err++;
                $display("FAIL even_result: par=%b words=%0d ovf=%b required par=%b words=%0d ovf=%b",
                         o_par_a, o_words_a, o_ovf_a, e.par, e.words_a, e.ovf_a);
              end
              n_vec++;
              if ({o_valid_b, o_par_b, o_words_b, o_ovf_b} !== {1'b1, ~e.par, e.words_a, e.ovf_a}) begin
                n_err++;
                $display("FAIL odd_result: v=%b par=%b words=%0d ovf=%b required v=1 par=%b words=%0d ovf=%b",
                         o_valid_b, o_par_b, o_words_b, o_ovf_b, ~e.par, e.words_a, e.ovf_a);
              end
              n_vec++;
              if ({o_valid_c, o_par_c, o_words_c, o_ovf_c} !== {1'b1, e.par, e.words_c, e.ovf_c}) begin
                n_err++;
                $display("FAIL sat_result: v=%b par=%b words=%0d ovf=%b required v=1 par=%b words=%0d ovf=%b",
                         o_valid_c, o_par_c, o_words_c, o_ovf_c, e.par, e.words_c, e.ovf_c);
              end
            end
          end else begin
            held = 1'b1;
            h_par = o_par_a; h_words = o_words_a; h_ovf = o_ovf_a;
          end
        end
      end
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepts the word.
  task automatic send(input logic [WIDTH-1:0] d, input logic last);
    int unsigned t;
    t = 0;
    i_valid = 1'b1; i_data = d; i_last = last;
    @(negedge clk);
    while (!i_ready_a && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!i_ready_a) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: i_ready=%b after %0d cycles required 1", i_ready_a, t);
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rn = 1'b0; i_valid = 1'b1; i_data = 32'hFFFF_FFFF; i_last = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({o_valid_a, o_par_a, o_words_a, o_ovf_a, i_ready_a} !== '0) begin
      n_err++;
      $display("FAIL reset_state: v=%b par=%b words=%0d ovf=%b rdy=%b required all 0",
               o_valid_a, o_par_a, o_words_a, o_ovf_a, i_ready_a);
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_last = 1'b0; rn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_word();
    o_ready = 1'b1;
    send(32'h0000_0103, 1'b1);
    n_vec++;
    if (o_valid_a !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early: o_valid=%b required 0", o_valid_a);
    end
    @(posedge clk); #1;
    n_vec++;
    if (o_valid_a !== 1'b1) begin
      n_err++;
      $display("FAIL latency_due: o_valid=%b required 1", o_valid_a);
    end
    wait_drain();
  endtask

  task automatic test_frame();
    o_ready = 1'b1;
    send(32'hFF00_0001, 1'b0);
    send(32'h0100_0001, 1'b0);
    send(32'h0000_0000, 1'b1);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    o_ready = 1'b0;
    send(32'h0000_0010, 1'b1);
    send(32'h0300_0000, 1'b1);
    i_valid = 1'b1; i_data = 32'h0001_0000; i_last = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_vec++;
      if ({o_valid_a, i_ready_a} !== 2'b10) begin
        n_err++;
        $display("FAIL b2b_stall: o_valid=%b i_ready=%b required o_valid=1 i_ready=0", o_valid_a, i_ready_a);
      end
    end
    @(posedge clk); #1;
    o_ready = 1'b1;
    send(32'h0001_0000, 1'b1);
    wait_drain();
  endtask

  task automatic test_abort();
    o_ready = 1'b1;
    send(32'h0000_0011, 1'b0);
    send(32'h0000_0022, 1'b0);
    i_abort = 1'b1; i_valid = 1'b1; i_data = 32'h8000_0000; i_last = 1'b1;
    @(negedge clk);
    n_vec++;
    if (i_ready_a !== 1'b0) begin
      n_err++;
      $display("FAIL abort_ready: i_ready=%b required 0", i_ready_a);
    end
    @(posedge clk); #1;
    i_abort = 1'b0; i_valid = 1'b0; i_last = 1'b0;
    send(32'h0000_0001, 1'b1);
    wait_drain();
  endtask

  task automatic test_saturate();
    o_ready = 1'b1;
    for (int i = 0; i < 20; i++) send($urandom, (i == 19));
    wait_drain();
    for (int i = 0; i < 3; i++) send($urandom, (i == 2));
    wait_drain();
  endtask

  task automatic test_reset_in_hold();
    o_ready = 1'b0;
    send(32'h8000_0000, 1'b1);
    send(32'h0000_0100, 1'b0);
    rn = 1'b0;
    @(negedge clk);
    n_vec++;
    if (i_ready_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: i_ready=%b required 0", i_ready_a);
    end
    @(posedge clk); #1;
    rn = 1'b1;
    n_vec++;
    if ({o_valid_a, o_par_a, o_words_a, o_ovf_a} !== '0) begin
      n_err++;
      $display("FAIL reset_hold: v=%b par=%b words=%0d ovf=%b required all 0",
               o_valid_a, o_par_a, o_words_a, o_ovf_a);
    end
    o_ready = 1'b1;
    send(32'h0000_0001, 1'b1);
    wait_drain();
  endtask

  initial begin
    fork
      run_monitor();
    join_none
    test_reset();
    test_single_word();
    test_frame();
    test_back_to_back();
    test_abort();
    test_saturate();
    test_reset_in_hold();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (o_valid_a !== 1'b0) begin
      n_err++;
      $display("FAIL final_idle: o_valid=%b required 0", o_valid_a);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
